// File: rtl/vga_wr_bridge_pkg.sv
// Shared definitions for the VGA posted-write bridge: FSM states, default window, counter sizing.
// No logic of its own; imported by the bridge and its FIFO.
package vga_wr_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   localparam logic [31:0] VGA_BASE_DFLT = 32'h0010_0000;
   localparam logic [31:0] VGA_SIZE_DFLT = 32'h0010_0000;

   // The phase counter only needs to reach TIMEOUT-1.
   function automatic int tmo_cnt_w(input int t);
      return (t <= 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/vga_wr_bridge_sync_fifo.sv
// Synchronous show-ahead FIFO: push visible at pop_dat one cycle later, level registered.
// Push is ignored when full and pop when empty; the caller observes full/empty for backpressure.
module sync_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == LW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign level   = cnt_q;
   assign pop_dat = mem_q[rd_ptr_q];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      mem_d   = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
      end
      // Power-of-two depth lets the pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/vga_wr_bridge.sv
// CPU-to-VGA posted-write bridge: window decode, FIFO, 4-phase req/ack drain with phase timeout.
// Accepted write reaches phy_req one cycle later; CPU is never stalled, full-FIFO writes set overflow.
module vga_wr_bridge
   import vga_wr_bridge_pkg::*;
#(
   parameter int            AW        = 32,
   parameter int            DW        = 32,
   parameter logic [AW-1:0] BASE_ADDR = AW'(VGA_BASE_DFLT),
   parameter logic [AW-1:0] WIN_SIZE  = AW'(VGA_SIZE_DFLT),
   parameter int            DEPTH     = 8,
   parameter int            TIMEOUT   = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            addr,
   input  logic [DW-1:0]            data,
   input  logic                     wr,
   output logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [AW-1:0]            phy_addr,
   output logic [DW-1:0]            phy_data,
   output logic                     phy_req,
   input  logic                     phy_ack,
   input  logic                     err_clr,
   output logic                     err_timeout,
   output logic                     overflow
);
   localparam int CW = tmo_cnt_w(TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
   // One extra bit so a window touching the top of the address space does not wrap.
   localparam logic [AW:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [AW:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phy_req_q, phy_req_d;
   logic [AW-1:0] phy_addr_q, phy_addr_d;
   logic [DW-1:0] phy_data_q, phy_data_d;
   logic          err_q, err_d;
   logic          ovf_q, ovf_d;

   entry_t        wr_entry, head;
   logic          hit, push, pop, ovf_set, tmo_set, tmo_hit;
   logic          fifo_full, fifo_empty;

   sync_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (wr_entry),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   always_comb begin
      hit           = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
      push          = wr && hit && !fifo_full;
      ovf_set       = wr && hit && fifo_full;
      wr_entry.addr = addr - BASE_ADDR;
      wr_entry.data = data;
      tmo_hit       = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      phy_req_d  = phy_req_q;
      phy_addr_d = phy_addr_q;
      phy_data_d = phy_data_q;
      pop        = 1'b0;
      tmo_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Holding off while ack is high covers an ack still asserted after a timeout.
            if (!fifo_empty && !phy_ack) begin
               pop        = 1'b1;
               phy_req_d  = 1'b1;
               phy_addr_d = head.addr;
               phy_data_d = head.data;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (phy_ack) begin
               phy_req_d = 1'b0;
               state_d   = ST_DROP;
            end else if (tmo_hit) begin
               phy_req_d = 1'b0;
               tmo_set   = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DROP: begin
            if (!phy_ack) begin
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               tmo_set = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            phy_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
      // A set event in the same cycle as err_clr wins.
      err_d = tmo_set | (err_q & ~err_clr);
      ovf_d = ovf_set | (ovf_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         phy_req_q  <= 1'b0;
         phy_addr_q <= '0;
         phy_data_q <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phy_req_q  <= phy_req_d;
         phy_addr_q <= phy_addr_d;
         phy_data_q <= phy_data_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   assign wr_ready    = !fifo_full;
   assign phy_req     = phy_req_q;
   assign phy_addr    = phy_addr_q;
   assign phy_data    = phy_data_q;
   assign err_timeout = err_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_vga_wr_bridge.sv
// Bench for vga_wr_bridge: randomized CPU writes and phy responder, queue scoreboard checked on each request.
module tb_vga_wr_bridge;
   localparam int          AW      = 32;
   localparam int          DW      = 32;
   localparam int          DEPTH   = 8;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] BASE    = 32'h0010_0000;
   localparam logic [31:0] WIN     = 32'h0010_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data = '0;
   logic          wr = 1'b0;
   logic          wr_ready;
   logic [3:0]    level;
   logic [AW-1:0] phy_addr;
   logic [DW-1:0] phy_data;
   logic          phy_req;
   logic          phy_ack = 1'b0;
   logic          err_clr = 1'b0;
   logic          err_timeout;
   logic          overflow;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } xfer_t;

   xfer_t       exp_q[$];
   xfer_t       mon_e;
   int          n_vec = 0;
   int          n_bad = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   bit          ack_en = 1'b0;
   bit          req_prev = 1'b0;
   int          dly = 0;
   logic [31:0] held_a = '0;
   logic [31:0] held_d = '0;

   always #5 clk = ~clk;

   vga_wr_bridge #(
      .AW(AW), .DW(DW), .BASE_ADDR(BASE), .WIN_SIZE(WIN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wr(wr), .wr_ready(wr_ready),
      .level(level), .phy_addr(phy_addr), .phy_data(phy_data), .phy_req(phy_req),
      .phy_ack(phy_ack), .err_clr(err_clr), .err_timeout(err_timeout), .overflow(overflow)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      longint unsigned x  = 64'(a);
      longint unsigned lo = 64'(BASE);
      longint unsigned hi = 64'(BASE) + 64'(WIN);
      return (x >= lo) && (x < hi);
   endfunction

   // Called at posedge+1; the write is presented for exactly the next edge.
   task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input bit acc);
      xfer_t e;
      wr = 1'b1; addr = a; data = d;
      @(posedge clk); #1;
      wr = 1'b0;
      if (acc) begin
         e.a = a - BASE;
         e.d = d;
         exp_q.push_back(e);
         acc_cnt++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      acc_cnt = 0;
      pop_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((exp_q.size() != 0 || level != 0 || phy_req || phy_ack) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      @(posedge clk); #1;
      if (t >= 300) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_drain: %0d transfers still outstanding, level %0d", nm, exp_q.size(), level);
      end
   endtask

   // Scoreboard monitor: each new request must match the oldest accepted write.
   always @(negedge clk) begin
      if (!rst) begin
         if (phy_req && !req_prev) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_xfer: addr 0x%0h data 0x%0h, none expected", phy_addr, phy_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("phy_addr", 64'(phy_addr), 64'(mon_e.a));
               chk("phy_data", 64'(phy_data), 64'(mon_e.d));
            end
            held_a = phy_addr;
            held_d = phy_data;
         end else if (phy_req) begin
            chk("phy_addr_stable", 64'(phy_addr), 64'(held_a));
            chk("phy_data_stable", 64'(phy_data), 64'(held_d));
         end
         chk("level", 64'(level), 64'(acc_cnt - pop_cnt));
      end
      req_prev = phy_req;
   end

   // Hardware responder: ack and release after 0..3 cycles each.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            phy_ack = 1'b0;
            dly = 0;
         end else if (!phy_ack && phy_req && ack_en) begin
            if (dly == 0) begin
               phy_ack = 1'b1;
               dly = $urandom_range(0, 3);
            end else dly--;
         end else if (phy_ack && !phy_req) begin
            if (dly == 0) begin
               phy_ack = 1'b0;
               dly = $urandom_range(0, 3);
            end else dly--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1);
   end

   initial begin
      int n;
      int t;
      int i;
      int guard;
      logic [31:0] a;
      logic [31:0] d;

      repeat (2) @(posedge clk);
      #1;
      do_reset();
      chk("rst_phy_req", 64'(phy_req), 64'd0);
      chk("rst_phy_addr", 64'(phy_addr), 64'd0);
      chk("rst_phy_data", 64'(phy_data), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("rst_err_timeout", 64'(err_timeout), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);

      // Single write: request rises one cycle after acceptance.
      ack_en = 1'b1;
      do_wr(32'h0010_0010, 32'h0000_CAFE, 1'b1);
      chk("lat_req_low_at_accept", 64'(phy_req), 64'd0);
      chk("lat_level_one", 64'(level), 64'd1);
      @(posedge clk); #1;
      chk("lat_req_high", 64'(phy_req), 64'd1);
      drain("single");

      // Window boundaries.
      do_wr(32'h000F_FFFF, 32'h1, in_win(32'h000F_FFFF));
      do_wr(32'h0020_0000, 32'h2, in_win(32'h0020_0000));
      chk("oow_level", 64'(level), 64'd0);
      do_wr(32'h0010_0000, 32'h3, in_win(32'h0010_0000));
      do_wr(32'h001F_FFFF, 32'h4, in_win(32'h001F_FFFF));
      drain("boundary");
      chk("oow_overflow", 64'(overflow), 64'd0);

      // Handshake timeout, then the queued entry still goes out.
      ack_en = 1'b0;
      do_wr(BASE + 32'h40, 32'h1111_0000, 1'b1);
      do_wr(BASE + 32'h44, 32'h2222_0000, 1'b1);
      t = 0;
      while (!phy_req && t < 50) begin @(posedge clk); #1; t++; end
      n = 0;
      while (phy_req && n < 100) begin n++; @(posedge clk); #1; end
      chk("tmo_req_cycles", 64'(n), 64'(TIMEOUT));
      chk("tmo_err_set", 64'(err_timeout), 64'd1);
      ack_en = 1'b1;
      drain("timeout");
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("tmo_err_clr", 64'(err_timeout), 64'd0);

      // Fill to DEPTH-1, then push while draining across the pointer wrap.
      ack_en = 1'b0;
      for (int k = 0; k < DEPTH; k++) do_wr(BASE + 32'(k * 4), 32'hA000_0000 + 32'(k), 1'b1);
      chk("wrap_level_dm1", 64'(level), 64'(DEPTH - 1));
      ack_en = 1'b1;
      i = DEPTH;
      guard = 0;
      while (i < 16 && guard < 500) begin
         guard++;
         if (wr_ready) begin
            do_wr(BASE + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
            i++;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("wrap_issued", 64'(i), 64'd16);
      drain("wrap");

      // Randomized traffic with random ack timing.
      i = 0;
      guard = 0;
      while (i < 300 && guard < 6000) begin
         guard++;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if (wr_ready) begin
            case ($urandom_range(0, 3))
               0: a = BASE + ($urandom % WIN);
               1: a = BASE - 32'd1 - 32'($urandom_range(0, 15));
               2: a = BASE + WIN + 32'($urandom_range(0, 15));
               default: a = $urandom;
            endcase
            d = $urandom;
            do_wr(a, d, in_win(a));
            i++;
         end
      end
      chk("rand_issued", 64'(i), 64'd300);
      drain("random");
      chk("rand_err_timeout", 64'(err_timeout), 64'd0);
      chk("rand_overflow", 64'(overflow), 64'd0);

      // Overflow: with no ack, one entry sits in phy and DEPTH more fit in the FIFO.
      ack_en = 1'b0;
      for (int k = 1; k <= DEPTH + 3; k++)
         do_wr(BASE + 32'h100 + 32'(k * 4), 32'hB000_0000 + 32'(k), k <= DEPTH + 1);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_level", 64'(level), 64'(DEPTH));
      chk("ovf_wr_ready", 64'(wr_ready), 64'd0);
      chk("ovf_req_held", 64'(phy_req), 64'd1);

      // Reset mid-handshake discards everything.
      do_reset();
      chk("mid_rst_phy_req", 64'(phy_req), 64'd0);
      chk("mid_rst_level", 64'(level), 64'd0);
      chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("mid_rst_overflow", 64'(overflow), 64'd0);
      chk("mid_rst_err_timeout", 64'(err_timeout), 64'd0);

      ack_en = 1'b1;
      do_wr(BASE + 32'h0FF0, 32'h5A5A_A5A5, 1'b1);
      drain("post_reset");
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
